// File: rtl/spi_tx_pkg.sv
// Shared types and defaults for the SPI frame transmitter.
// Optional receive capture is enabled with the SPI_TX_RXCAP_EN macro (see spi_frame_tx).
`timescale 1ns/1ps
package spi_tx_pkg;

  localparam int FRAME_BITS_DEF = 16;
  localparam int CLK_DIV_DEF    = 4;

  // Frame sequencer states: SETUP presents the MSB, HIGH/LOW form the sclk
  // half-periods, HOLD keeps cs low for one half-period after the last bit.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4
  } state_t;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick generator: pulses tick on the last cycle of every CLK_DIV-cycle
// window. restart holds the counter at 0 so a fresh window begins on release.
`timescale 1ns/1ps
module spi_tick_gen
  import spi_tx_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..CLK_DIV-1 and wrap; restart forces the window back to its start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !restart && (cnt == LAST);

endmodule

// File: rtl/spi_frame_tx.sv
// SPI mode-0 frame transmitter (MSB first, cs active low, sclk idle low).
// Handshake: start is sampled only in IDLE when done is low; acceptance raises
// busy, which stays high until the cycle done pulses; start is ignored otherwise.
// Every state lasts CLK_DIV cycles, so a frame takes (2*FRAME_BITS+1)*CLK_DIV
// cycles from the accept edge to done. Every state change other than IDLE->SETUP
// happens on a tick, so the tick counter wraps exactly at each state entry.
// Define SPI_TX_RXCAP_EN to capture sdi on each rising sclk into rx_data;
// otherwise rx_data is tied to 0 and sdi is unused.
`timescale 1ns/1ps
module spi_frame_tx
  import spi_tx_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEF,
  parameter int FRAME_BITS = FRAME_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] tx_data,
  input  logic                  sdi,
  output logic                  sclk,
  output logic                  cs,
  output logic                  sdo,
  output logic                  busy,
  output logic                  done,
  output logic [FRAME_BITS-1:0] rx_data,
  output state_t                fsm_state
);

  localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  state_t                state;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] shreg_next;
  logic [BW-1:0]         bit_cnt;
  logic                  tick;
  logic                  sclk_rise;

  assign shreg_next = shreg << 1;
  assign sclk_rise  = tick && (state == SETUP || state == LOW);
  assign fsm_state  = state;

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (state == IDLE),
    .tick    (tick)
  );

  // Frame sequencer with registered SPI pins, busy and done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cs      <= 1'b1;
      sclk    <= 1'b0;
      sdo     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !done) begin
            shreg   <= tx_data;
            bit_cnt <= BW'(FRAME_BITS - 1);
            sdo     <= tx_data[FRAME_BITS-1];
            cs      <= 1'b0;
            busy    <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (tick) begin
            sclk  <= 1'b1;
            state <= HIGH;
          end
        end
        HIGH: begin
          if (tick) begin
            sclk <= 1'b0;
            if (bit_cnt == '0) begin
              state <= HOLD;
            end else begin
              shreg   <= shreg_next;
              sdo     <= shreg_next[FRAME_BITS-1];
              bit_cnt <= bit_cnt - 1'b1;
              state   <= LOW;
            end
          end
        end
        LOW: begin
          if (tick) begin
            sclk  <= 1'b1;
            state <= HIGH;
          end
        end
        HOLD: begin
          if (tick) begin
            cs    <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            sdo   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_TX_RXCAP_EN
  logic [FRAME_BITS-1:0] rx_shift;
  logic [FRAME_BITS-1:0] rx_q;

  // Shift sdi in on every rising sclk; publish the word as done is raised.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_shift <= '0;
      rx_q     <= '0;
    end else begin
      if (sclk_rise) rx_shift <= FRAME_BITS'({rx_shift, sdi});
      if (state == HOLD && tick) rx_q <= rx_shift;
    end
  end

  assign rx_data = rx_q;
`else
  logic sdi_unused;
  logic rise_unused;

  assign sdi_unused  = sdi;
  assign rise_unused = sclk_rise;
  assign rx_data     = '0;
`endif

endmodule

// File: tb/tb_spi_frame_tx.sv
// Self-checking bench for spi_frame_tx: default instance (CLK_DIV=4, 16 bits)
// plus a CLK_DIV=2 instance for timing. sdi is looped back from sdo.
`timescale 1ns/1ps
module tb_spi_frame_tx;
  import spi_tx_pkg::*;

  localparam int FB  = 16;
  localparam int CD  = 4;
  localparam int CD2 = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic          start = 1'b0;
  logic [FB-1:0] tx_data = '0;
  wire           sdi;
  logic          sclk, cs, sdo, busy, done;
  logic [FB-1:0] rx_data;
  state_t        st1;
  assign sdi = sdo;

  spi_frame_tx #(.CLK_DIV(CD), .FRAME_BITS(FB)) dut (
    .clk(clk), .reset(rst_n), .start(start), .tx_data(tx_data), .sdi(sdi),
    .sclk(sclk), .cs(cs), .sdo(sdo), .busy(busy), .done(done),
    .rx_data(rx_data), .fsm_state(st1)
  );

  // CLK_DIV=2 instance
  logic          start2 = 1'b0;
  logic [FB-1:0] tx2 = '0;
  wire           sdi2;
  logic          sclk2, cs2, sdo2, busy2, done2;
  logic [FB-1:0] rx2;
  state_t        st2;
  assign sdi2 = sdo2;

  spi_frame_tx #(.CLK_DIV(CD2), .FRAME_BITS(FB)) dut2 (
    .clk(clk), .reset(rst_n), .start(start2), .tx_data(tx2), .sdi(sdi2),
    .sclk(sclk2), .cs(cs2), .sdo(sdo2), .busy(busy2), .done(done2),
    .rx_data(rx2), .fsm_state(st2)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference rules
  function automatic int exp_latency(input int cd, input int fb);
    return (2 * fb + 1) * cd;
  endfunction

  function automatic logic [FB-1:0] exp_rx(input logic [FB-1:0] word);
`ifdef SPI_TX_RXCAP_EN
    return word;
`else
    return '0;
`endif
  endfunction

  // Drive one frame and observe it. k counts negedges after the accept edge;
  // an output sampled at negedge k reflects the edge k-1 cycles after acceptance.
  task automatic run_frame(
    input  logic [FB-1:0] data,
    input  int            inject_at,
    input  int            change_at,
    output logic [FB-1:0] bits,
    output int            nbits,
    output int            latency,
    output int            ndone,
    output int            glitches,
    output int            ctl_err,
    output logic [FB-1:0] rx_at_done
  );
    logic psclk, psdo;
    bits = '0; nbits = 0; latency = -1; ndone = 0; glitches = 0; ctl_err = 0;
    rx_at_done = '0;
    @(negedge clk);
    tx_data = data;
    start = 1'b1;
    psclk = sclk;
    psdo = sdo;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (sclk && !psclk) begin
        bits = {bits[FB-2:0], sdo};
        nbits++;
      end
      if (sclk && psclk && sdo !== psdo) glitches++;
      if (done) begin
        ndone++;
        if (latency < 0) begin
          latency = k - 1;
          rx_at_done = rx_data;
        end
      end
      if (latency < 0) begin
        if (busy !== 1'b1 || cs !== 1'b0) ctl_err++;
      end else begin
        if (busy !== 1'b0 || cs !== 1'b1) ctl_err++;
      end
      if (k == inject_at) begin
        start = 1'b1;
        tx_data = FB'($urandom);
      end
      if (k == inject_at + 1) start = 1'b0;
      if (k == change_at) tx_data = '0;
      psclk = sclk;
      psdo = sdo;
      if (latency >= 0 && k >= latency + 8) break;
    end
    start = 1'b0;
  endtask

  task automatic do_frame(input string tag, input logic [FB-1:0] data,
                          input int inject_at, input int change_at);
    logic [FB-1:0] bits, rxw;
    int nbits, lat, ndone, gl, ce;
    run_frame(data, inject_at, change_at, bits, nbits, lat, ndone, gl, ce, rxw);
    check({tag, ".bits"}, 32'(bits), 32'(data));
    check({tag, ".nbits"}, nbits, FB);
    check({tag, ".latency"}, lat, exp_latency(CD, FB));
    check({tag, ".ndone"}, ndone, 1);
    check({tag, ".sdo_stable"}, gl, 0);
    check({tag, ".busy_cs"}, ce, 0);
    check({tag, ".rx_data"}, 32'(rxw), 32'(exp_rx(data)));
  endtask

  initial begin : main
    logic psclk;
    int rises, ndone_rst, first, second, lat2;

    // reset state
    repeat (3) @(negedge clk);
    check("rst.cs", cs, 1);
    check("rst.sclk", sclk, 0);
    check("rst.sdo", sdo, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.rx_data", 32'(rx_data), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // known pattern, the receiver should read 253
    do_frame("f00fd", 16'h00FD, -1, -1);

    // random frames
    for (int i = 0; i < 3; i++) do_frame("rand", FB'($urandom), -1, -1);

    // start 20 cycles into a frame is ignored, then a fresh frame goes out
    do_frame("busy_start", FB'($urandom), 20, -1);
    do_frame("after_busy", FB'($urandom), -1, -1);

    // tx_data changed one cycle after acceptance
    do_frame("txchg", 16'hA5A5, -1, 1);

    // start during the done cycle is ignored
    do_frame("done_start", FB'($urandom), exp_latency(CD, FB) + 1, -1);

    // reset after the 8th rising sclk
    @(negedge clk);
    tx_data = FB'($urandom);
    start = 1'b1;
    rises = 0;
    psclk = sclk;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (sclk && !psclk) rises++;
      psclk = sclk;
      if (rises == 8) break;
    end
    check("mid.rises", rises, 8);
    #2 rst_n = 1'b0;
    #1;
    check("mid.cs", cs, 1);
    check("mid.sclk", sclk, 0);
    check("mid.busy", busy, 0);
    check("mid.sdo", sdo, 0);
    check("mid.done", done, 0);
    ndone_rst = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) ndone_rst++;
    end
    check("mid.no_done", ndone_rst, 0);
    check("mid.busy_after", busy, 0);
    do_frame("recover", FB'($urandom), -1, -1);

    // CLK_DIV=2 instance: sclk period and latency
    @(negedge clk);
    tx2 = FB'($urandom);
    start2 = 1'b1;
    first = -1; second = -1; lat2 = -1;
    psclk = sclk2;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) start2 = 1'b0;
      if (sclk2 && !psclk) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
      if (done2 && lat2 < 0) lat2 = k - 1;
      psclk = sclk2;
      if (lat2 >= 0) break;
    end
    check("cd2.period", second - first, 2 * CD2);
    check("cd2.latency", lat2, exp_latency(CD2, FB));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
